// File: rtl/fll_acquisition_controller.sv
// FLL acquisition controller: sweeps the NCO word, pulls in on detect, tracks in lock.
// Latency: freq_word/freq_valid register one cycle after an accepted err sample.
// Backpressure: err_ready is low only in IDLE; no internal buffering.
module fll_acquisition_controller #(
  parameter int FreqWidth       = 24,
  parameter int FreqLimit       = 4194304,
  parameter int SweepStep       = 4096,
  parameter int DetectThreshold = 256,
  parameter int LockThreshold   = 32,
  parameter int UnlockThreshold = 128,
  parameter int LockCount       = 16,
  parameter int UnlockCount     = 8,
  parameter int PullInTimeout   = 1024,
  parameter int AcqShift        = 6,
  parameter int TrackShift      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [11:0]          err,
  input  logic                        err_valid,
  output logic                        err_ready,
  output logic signed [FreqWidth-1:0] freq_word,
  output logic                        freq_valid,
  output logic                        locked,
  output logic [1:0]                  state
);

  localparam int W2 = FreqWidth + 2;
  localparam int CntMax = (PullInTimeout > LockCount)
                          ? ((PullInTimeout > UnlockCount) ? PullInTimeout : UnlockCount)
                          : ((LockCount > UnlockCount) ? LockCount : UnlockCount);
  localparam int CntW = $clog2(CntMax + 1);

  localparam logic signed [W2-1:0] LimP  = W2'(FreqLimit);
  localparam logic signed [W2-1:0] LimN  = -LimP;
  localparam logic signed [W2-1:0] StepW = W2'(SweepStep);
  localparam logic [CntW-1:0] LockCnt    = CntW'(LockCount);
  localparam logic [CntW-1:0] UnlockCnt  = CntW'(UnlockCount);
  localparam logic [CntW-1:0] TmoCnt     = CntW'(PullInTimeout);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntZero    = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_PULL  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [FreqWidth-1:0]   r_fw, w_fw_nxt;
  logic                   r_fv, w_fv_nxt;
  logic                   r_dir, w_dir_nxt;   // 0 = sweeping upward
  logic [CntW-1:0]        r_lock_cnt, w_lock_nxt;
  logic [CntW-1:0]        r_tmo_cnt, w_tmo_nxt;
  logic [CntW-1:0]        r_unl_cnt, w_unl_nxt;

  logic                   w_acc;
  logic [11:0]            w_abs;
  logic signed [W2-1:0]   w_fw_ext, w_err_ext;
  logic signed [W2-1:0]   w_acq_sat, w_trk_sat, w_swp_sum, w_swp_sat;
  logic                   w_swp_over;
  logic [CntW-1:0]        w_lock_inc, w_tmo_inc, w_unl_inc;

  function automatic logic signed [W2-1:0] f_sat(input logic signed [W2-1:0] v);
    if (v > LimP)      f_sat = LimP;
    else if (v < LimN) f_sat = LimN;
    else               f_sat = v;
  endfunction

  // Magnitude is 12-bit unsigned so -2048 maps to 2048 rather than wrapping.
  assign w_abs      = err[11] ? (~err + 12'd1) : err;
  assign w_acc      = err_valid && (r_state != S_IDLE);
  assign w_fw_ext   = {{2{r_fw[FreqWidth-1]}}, r_fw};
  assign w_err_ext  = {{(W2-12){err[11]}}, err};
  assign w_acq_sat  = f_sat(w_fw_ext + (w_err_ext <<< AcqShift));
  assign w_trk_sat  = f_sat(w_fw_ext + (w_err_ext <<< TrackShift));
  assign w_swp_sum  = r_dir ? (w_fw_ext - StepW) : (w_fw_ext + StepW);
  assign w_swp_over = (w_swp_sum > LimP) || (w_swp_sum < LimN);
  assign w_swp_sat  = f_sat(w_swp_sum);
  assign w_lock_inc = r_lock_cnt + CntOne;
  assign w_tmo_inc  = r_tmo_cnt + CntOne;
  assign w_unl_inc  = r_unl_cnt + CntOne;

  // State, frequency word and counters register; rst discards any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fw       <= '0;
      r_fv       <= 1'b0;
      r_dir      <= 1'b0;
      r_lock_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_unl_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fw       <= w_fw_nxt;
      r_fv       <= w_fv_nxt;
      r_dir      <= w_dir_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_unl_cnt  <= w_unl_nxt;
    end
  end

  // Next state and datapath; only accepted samples move the word or counters.
  always_comb begin
    w_state_nxt = r_state;
    w_fw_nxt    = r_fw;
    w_fv_nxt    = 1'b0;
    w_dir_nxt   = r_dir;
    w_lock_nxt  = r_lock_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_unl_nxt   = r_unl_cnt;
    if (!enable) begin
      // Abort wins over any sample accepted this cycle.
      w_state_nxt = S_IDLE;
      w_fw_nxt    = '0;
      w_dir_nxt   = 1'b0;
      w_lock_nxt  = CntZero;
      w_tmo_nxt   = CntZero;
      w_unl_nxt   = CntZero;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SWEEP;
          w_fw_nxt    = '0;
          w_dir_nxt   = 1'b0;
          w_lock_nxt  = CntZero;
          w_tmo_nxt   = CntZero;
          w_unl_nxt   = CntZero;
        end
        S_SWEEP: begin
          if (w_acc) begin
            w_fv_nxt = 1'b1;
            if (w_abs >= 12'(DetectThreshold)) begin
              // Detecting sample applies the pull-in update instead of a step.
              w_state_nxt = S_PULL;
              w_fw_nxt    = w_acq_sat[FreqWidth-1:0];
              w_lock_nxt  = CntZero;
              w_tmo_nxt   = CntZero;
              w_unl_nxt   = CntZero;
            end else begin
              // A step landing exactly on the limit is legal; only overshoot reverses.
              w_fw_nxt = w_swp_sat[FreqWidth-1:0];
              if (w_swp_over) w_dir_nxt = ~r_dir;
            end
          end
        end
        S_PULL: begin
          if (w_acc) begin
            w_fv_nxt   = 1'b1;
            w_fw_nxt   = w_acq_sat[FreqWidth-1:0];
            w_lock_nxt = (w_abs <= 12'(LockThreshold)) ? w_lock_inc : CntZero;
            w_tmo_nxt  = w_tmo_inc;
            // Lock is checked first so it wins a same-sample timeout.
            if ((w_abs <= 12'(LockThreshold)) && (w_lock_inc == LockCnt)) begin
              w_state_nxt = S_LOCK;
              w_lock_nxt  = CntZero;
              w_tmo_nxt   = CntZero;
              w_unl_nxt   = CntZero;
            end else if (w_tmo_inc == TmoCnt) begin
              w_state_nxt = S_SWEEP;
              w_lock_nxt  = CntZero;
              w_tmo_nxt   = CntZero;
              w_unl_nxt   = CntZero;
            end
          end
        end
        default: begin
          if (w_acc) begin
            w_fv_nxt  = 1'b1;
            w_fw_nxt  = w_trk_sat[FreqWidth-1:0];
            w_unl_nxt = (w_abs > 12'(UnlockThreshold)) ? w_unl_inc : CntZero;
            if ((w_abs > 12'(UnlockThreshold)) && (w_unl_inc == UnlockCnt)) begin
              w_state_nxt = S_PULL;
              w_lock_nxt  = CntZero;
              w_tmo_nxt   = CntZero;
              w_unl_nxt   = CntZero;
            end
          end
        end
      endcase
    end
  end

  // Outputs decoded from registered state and datapath.
  always_comb begin
    err_ready  = (r_state != S_IDLE);
    locked     = (r_state == S_LOCK);
    state      = r_state;
    freq_word  = r_fw;
    freq_valid = r_fv;
  end

endmodule

// File: tb/tb_fll_acquisition_controller.sv
module tb_fll_acquisition_controller;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [11:0] err;
  logic               err_valid;
  logic               err_ready;
  logic signed [23:0] freq_word;
  logic               freq_valid;
  logic               locked;
  logic [1:0]         state;

  int n_cmp = 0;
  int n_bad = 0;

  fll_acquisition_controller dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .err       (err),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .freq_word (freq_word),
    .freq_valid(freq_valid),
    .locked    (locked),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic send(input int e);
    err       = e[11:0];
    err_valid = 1'b1;
    @(posedge clk);
    #1;
    err_valid = 1'b0;
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; err = 12'sd300; err_valid = 1'b1;
    idle_cyc(); idle_cyc();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d want=0", state); end
    n_cmp++; if (freq_word !== 24'sd0) begin n_bad++; $display("FAIL reset_fw got=%0d want=0", freq_word); end
    n_cmp++; if (freq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv got=%b want=0", freq_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    n_cmp++; if (err_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", err_ready); end
    rst = 1'b0; enable = 1'b0; err_valid = 1'b0;
    idle_cyc();
  endtask

  task automatic test_sweep();
    int exp;
    enable = 1'b1;
    idle_cyc();
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL sweep_entry got=%0d want=1", state); end
    n_cmp++; if (err_ready !== 1'b1) begin n_bad++; $display("FAIL sweep_ready got=%b want=1", err_ready); end
    for (int i = 1; i <= 1024; i++) begin
      send(0);
      exp = i * 4096;
      n_cmp++; if ($signed(freq_word) !== exp) begin n_bad++; $display("FAIL sweep_up[%0d] got=%0d want=%0d", i, freq_word, exp); end
      n_cmp++; if (freq_valid !== 1'b1 || locked !== 1'b0) begin n_bad++; $display("FAIL sweep_flags[%0d] fv=%b lk=%b want fv=1 lk=0", i, freq_valid, locked); end
    end
    send(0);
    n_cmp++; if ($signed(freq_word) !== 4194304) begin n_bad++; $display("FAIL sweep_sat got=%0d want=4194304", freq_word); end
    send(0);
    n_cmp++; if ($signed(freq_word) !== 4190208) begin n_bad++; $display("FAIL sweep_down1 got=%0d want=4190208", freq_word); end
    send(0);
    n_cmp++; if ($signed(freq_word) !== 4186112) begin n_bad++; $display("FAIL sweep_down2 got=%0d want=4186112", freq_word); end
    n_cmp++; if (state !== 2'd1 || locked !== 1'b0) begin n_bad++; $display("FAIL sweep_end state=%0d lk=%b want 1/0", state, locked); end
  endtask

  task automatic test_detect();
    rst = 1'b1; idle_cyc(); rst = 1'b0; idle_cyc();
    for (int i = 0; i < 10; i++) send(0);
    n_cmp++; if ($signed(freq_word) !== 40960) begin n_bad++; $display("FAIL detect_pre got=%0d want=40960", freq_word); end
    send(300);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL detect_state got=%0d want=2", state); end
    n_cmp++; if ($signed(freq_word) !== 60160) begin n_bad++; $display("FAIL detect_fw got=%0d want=60160", freq_word); end
    for (int i = 0; i < 15; i++) send(10);
    n_cmp++; if (state !== 2'd2 || locked !== 1'b0) begin n_bad++; $display("FAIL pull_15 state=%0d lk=%b want 2/0", state, locked); end
    n_cmp++; if ($signed(freq_word) !== 69760) begin n_bad++; $display("FAIL pull_fw got=%0d want=69760", freq_word); end
    send(10);
    n_cmp++; if (state !== 2'd3 || locked !== 1'b1) begin n_bad++; $display("FAIL lock_16 state=%0d lk=%b want 3/1", state, locked); end
    n_cmp++; if ($signed(freq_word) !== 70400) begin n_bad++; $display("FAIL lock_fw got=%0d want=70400", freq_word); end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 7; i++) send(500);
    n_cmp++; if (state !== 2'd3 || locked !== 1'b1) begin n_bad++; $display("FAIL unlock_7 state=%0d lk=%b want 3/1", state, locked); end
    n_cmp++; if ($signed(freq_word) !== 84400) begin n_bad++; $display("FAIL track_fw got=%0d want=84400", freq_word); end
    send(0);
    for (int i = 0; i < 7; i++) send(500);
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL unlock_cleared got=%0d want=3", state); end
    send(500);
    n_cmp++; if (state !== 2'd2 || locked !== 1'b0) begin n_bad++; $display("FAIL unlock_8 state=%0d lk=%b want 2/0", state, locked); end
    n_cmp++; if ($signed(freq_word) !== 100400) begin n_bad++; $display("FAIL unlock_fw got=%0d want=100400", freq_word); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 1023; i++) send((i % 2 == 0) ? 200 : -200);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL tmo_1023 got=%0d want=2", state); end
    n_cmp++; if ($signed(freq_word) !== 113200) begin n_bad++; $display("FAIL tmo_fw1023 got=%0d want=113200", freq_word); end
    send(-200);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL tmo_1024 got=%0d want=1", state); end
    n_cmp++; if ($signed(freq_word) !== 100400) begin n_bad++; $display("FAIL tmo_fw got=%0d want=100400", freq_word); end
  endtask

  task automatic test_stall();
    err = 12'sd999; err_valid = 1'b0;
    for (int i = 0; i < 5; i++) idle_cyc();
    n_cmp++; if ($signed(freq_word) !== 100400 || freq_valid !== 1'b0 || state !== 2'd1) begin n_bad++; $display("FAIL stall_sweep fw=%0d fv=%b st=%0d want 100400/0/1", freq_word, freq_valid, state); end
    send(-300);
    n_cmp++; if (state !== 2'd2 || $signed(freq_word) !== 81200) begin n_bad++; $display("FAIL stall_detect st=%0d fw=%0d want 2/81200", state, freq_word); end
    for (int i = 0; i < 15; i++) begin
      send(5);
      idle_cyc(); idle_cyc(); idle_cyc();
    end
    n_cmp++; if ($signed(freq_word) !== 86000 || freq_valid !== 1'b0 || state !== 2'd2) begin n_bad++; $display("FAIL stall_pull fw=%0d fv=%b st=%0d want 86000/0/2", freq_word, freq_valid, state); end
    send(5);
    n_cmp++; if (state !== 2'd3 || $signed(freq_word) !== 86320) begin n_bad++; $display("FAIL stall_lock st=%0d fw=%0d want 3/86320", state, freq_word); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) send(500);
    n_cmp++; if (state !== 2'd2 || $signed(freq_word) !== 102320) begin n_bad++; $display("FAIL abort_pre st=%0d fw=%0d want 2/102320", state, freq_word); end
    err = 12'sd300; err_valid = 1'b1; enable = 1'b0;
    idle_cyc();
    err_valid = 1'b0;
    n_cmp++; if (state !== 2'd0 || $signed(freq_word) !== 0) begin n_bad++; $display("FAIL abort st=%0d fw=%0d want 0/0", state, freq_word); end
    n_cmp++; if (err_ready !== 1'b0 || freq_valid !== 1'b0) begin n_bad++; $display("FAIL abort_flags rdy=%b fv=%b want 0/0", err_ready, freq_valid); end
  endtask

  task automatic test_lock_wins();
    enable = 1'b1;
    idle_cyc();
    send(300);
    n_cmp++; if (state !== 2'd2 || $signed(freq_word) !== 19200) begin n_bad++; $display("FAIL lw_entry st=%0d fw=%0d want 2/19200", state, freq_word); end
    for (int i = 0; i < 1008; i++) send((i % 2 == 0) ? 200 : -200);
    for (int i = 0; i < 15; i++) send(0);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL lw_1023 got=%0d want=2", state); end
    send(0);
    n_cmp++; if (state !== 2'd3 || locked !== 1'b1) begin n_bad++; $display("FAIL lw_tie st=%0d lk=%b want 3/1", state, locked); end
  endtask

  task automatic test_saturation();
    rst = 1'b1; err = 12'sd500; err_valid = 1'b1;
    idle_cyc();
    n_cmp++; if (state !== 2'd0 || $signed(freq_word) !== 0 || freq_valid !== 1'b0) begin n_bad++; $display("FAIL midrst st=%0d fw=%0d fv=%b want 0/0/0", state, freq_word, freq_valid); end
    rst = 1'b0; err_valid = 1'b0;
    idle_cyc();
    for (int i = 0; i < 1024; i++) send(0);
    send(256);
    n_cmp++; if (state !== 2'd2 || $signed(freq_word) !== 4194304) begin n_bad++; $display("FAIL sat_detect st=%0d fw=%0d want 2/4194304", state, freq_word); end
    for (int i = 0; i < 16; i++) send(0);
    send(-76);
    n_cmp++; if (state !== 2'd3 || $signed(freq_word) !== 4194000) begin n_bad++; $display("FAIL sat_pre st=%0d fw=%0d want 3/4194000", state, freq_word); end
    send(2047);
    n_cmp++; if ($signed(freq_word) !== 4194304) begin n_bad++; $display("FAIL sat_pos got=%0d want=4194304", freq_word); end
    send(-2048);
    n_cmp++; if ($signed(freq_word) !== 4186112) begin n_bad++; $display("FAIL sat_neg2048 got=%0d want=4186112", freq_word); end
    for (int i = 0; i < 5; i++) send(500);
    n_cmp++; if (state !== 2'd3 || $signed(freq_word) !== 4194304) begin n_bad++; $display("FAIL abs_7 st=%0d fw=%0d want 3/4194304", state, freq_word); end
    send(500);
    n_cmp++; if (state !== 2'd2 || locked !== 1'b0) begin n_bad++; $display("FAIL abs_unlock st=%0d lk=%b want 2/0", state, locked); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; err = '0; err_valid = 1'b0;
    test_reset();
    test_sweep();
    test_detect();
    test_unlock();
    test_timeout();
    test_stall();
    test_abort();
    test_lock_wins();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fll_acquisition_controller.md
FLL_ACQUISITION_CONTROLLER -- requirements
Module: fll_acquisition_controller

Interface
REQ-001 The block SHALL have parameter FreqWidth, default 24, meaning the NCO frequency-word width in bits.
REQ-002 The block SHALL have parameter FreqLimit, default 4194304, meaning the symmetric saturation magnitude of freq_word.
REQ-003 The block SHALL have parameter SweepStep, default 4096, meaning the freq_word increment per accepted sample in SWEEP.
REQ-004 The block SHALL have parameter DetectThreshold, default 256, meaning the |err| at or above which a carrier is detected.
REQ-005 The block SHALL have parameter LockThreshold, default 32, meaning the |err| at or below which a sample counts as in-lock.
REQ-006 The block SHALL have parameter UnlockThreshold, default 128, meaning the |err| above which a sample counts as out-of-lock.
REQ-007 The block SHALL have parameters LockCount 16, UnlockCount 8 and PullInTimeout 1024, each a count of accepted samples.
REQ-008 The block SHALL have parameters AcqShift 6 and TrackShift 2, each the left-shift gain applied to err in PULL_IN and LOCKED respectively.
REQ-009 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 enable  input  1  run request; low forces IDLE.
REQ-012 err  input  12  signed loop-filter frequency error.
REQ-013 err_valid  input  1  err qualifier.
REQ-014 err_ready  output  1  high in every state except IDLE; a sample is accepted when err_valid and err_ready are both high.
REQ-015 freq_word  output  FreqWidth  signed NCO frequency control word.
REQ-016 freq_valid  output  1  one-cycle pulse when freq_word updates.
REQ-017 locked  output  1  high only in LOCKED.
REQ-018 state  output  2  IDLE=0, SWEEP=1, PULL_IN=2, LOCKED=3.

Function
REQ-019 The block SHALL compute |err| as an unsigned 12-bit value, with |-2048| = 2048 and no wrap.
REQ-020 All freq_word updates SHALL be computed at FreqWidth+2 bits, err sign-extended before shifting, then saturated to [-FreqLimit, +FreqLimit].
REQ-021 freq_word and freq_valid SHALL be registered and update the cycle after an accepted sample (latency 1); freq_valid SHALL be low in every other cycle.
REQ-022 In IDLE, freq_word SHALL be 0; when enable is high, the block SHALL go to SWEEP on the next cycle with sweep direction positive.
REQ-023 In SWEEP, each accepted sample SHALL move freq_word by +/-SweepStep in the sweep direction.
REQ-024 When a SWEEP step would pass +/-FreqLimit, freq_word SHALL saturate at the limit and the sweep direction SHALL invert for the next step.
REQ-025 In SWEEP, an accepted sample with |err| >= DetectThreshold SHALL cause the transition to PULL_IN; that sample SHALL not step the sweep and SHALL apply the PULL_IN update.
REQ-026 In PULL_IN, freq_word SHALL be updated to freq_word + (err << AcqShift).
REQ-027 In PULL_IN, the lock counter SHALL increment on accepted samples with |err| <= LockThreshold and clear on other accepted samples.
REQ-028 When the lock counter reaches LockCount, the block SHALL enter LOCKED.
REQ-029 In PULL_IN, the timeout counter SHALL count every accepted sample.
REQ-030 When the timeout counter reaches PullInTimeout without lock, the block SHALL return to SWEEP with freq_word held.
REQ-031 If the lock and timeout conditions occur on the same sample, lock SHALL win.
REQ-032 In LOCKED, freq_word SHALL be updated to freq_word + (err << TrackShift).
REQ-033 In LOCKED, the unlock counter SHALL increment on accepted samples with |err| > UnlockThreshold and clear on other accepted samples.
REQ-034 When the unlock counter reaches UnlockCount, the block SHALL enter PULL_IN with the lock and timeout counters cleared.
REQ-035 Every state entry SHALL clear all three counters.
REQ-036 Cycles without an accepted sample SHALL change neither the counters nor freq_word.
REQ-037 enable low in any state SHALL force IDLE on the next cycle, set freq_word to 0 and suppress freq_valid, even if a sample is accepted in that same cycle.

Reset
REQ-038 On rst, the block SHALL set state=IDLE, freq_word=0, freq_valid=0, locked=0, err_ready=0, all counters=0 and sweep direction positive.
REQ-039 rst SHALL take priority over enable and err_valid, and reset mid-operation SHALL discard any pending update.

Verification
REQ-040 Sweep: enable=1 with err=0 on every cycle -> freq_word = 4096, 8192, ... until 4194304, then it steps down by 4096; locked=0 throughout.
REQ-041 Detect/pull-in: in SWEEP at freq_word=40960, send err=300 -> state=2 and freq_word=60160; then 16 samples of err=10 -> state=3 and locked=1 on the cycle after the 16th sample.
REQ-042 Timeout: in PULL_IN, send 1024 samples alternating err=+200 and -200 -> state=1 after the 1024th sample, with freq_word equal to its value at PULL_IN entry.
REQ-043 Unlock: in LOCKED, send 7 samples of err=500, then err=0, then 8 samples of err=500 -> stays LOCKED until the 8th of the final run, then state=2 and locked=0.
REQ-044 Saturation and abs: in LOCKED at freq_word=4194000, send err=2047 -> freq_word=4194304; send err=-2048 -> |err| counts as 2048 and is treated as out-of-lock.
REQ-045 Stalls and abort: gaps in err_valid leave freq_word and counters unchanged; deasserting enable mid-PULL_IN gives state=0, freq_word=0 and err_ready=0 on the next cycle.
